// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. It accepts two WIDTH-bit operands on a start request. It
// then adds them one bit per clock, LSB first, using a single full adder and
// a carry flip-flop. When every bit has been processed it publishes the
// registered result on sum/carry and pulses done for one cycle.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      begin an addition (honoured only in IDLE)
//   a      in   WIDTH  first operand, captured when start is accepted
//   b      in   WIDTH  second operand, captured when start is accepted
//   busy   out  1      high exactly while bits are being processed (RUN)
//   done   out  1      one-cycle pulse marking a new valid result (DONE)
//   sum    out  WIDTH  registered result, a+b modulo 2^WIDTH
//   carry  out  1      registered carry-out of the most significant bit
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sum/carry hold the last completed result
// RUN   | one bit per edge; operands shift right, sum bits shift in MSB
// DONE  | result just published; done high; returns to IDLE next edge
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // The counter must be able to hold WIDTH itself, so it never wraps.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_c;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_d;

    // Full adder from two half-adder stages plus an OR on the carries.
    always_comb begin
        ha1_s = a_q[0] ^ b_q[0];
        ha1_c = a_q[0] & b_q[0];
        fa_s  = ha1_s ^ c_q;
        ha2_c = ha1_s & c_q;
        fa_c  = ha1_c | ha2_c;
    end

    // Shift paths. The result register fills from the MSB, so after WIDTH
    // shifts bit 0 of the sum has arrived at bit 0. Indexing rather than
    // concatenation keeps this legal for WIDTH=1.
    always_comb begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        res_d           = res_q >> 1;
        res_d[WIDTH-1]  = fa_s;
        cnt_d           = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    res_q <= res_d;
                    c_q   <= fa_c;
                    cnt_q <= cnt_d;
                    // Only the completed word ever reaches sum.
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= res_d;
                        carry_q <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have port a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 SHALL have port sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
REQ-010 SHALL have port carry  output  1  registered carry-out of the most significant bit.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE; all outputs SHALL be registered or decoded from state only.
REQ-012 IDLE: on an edge with start=1, load a and b into internal shift registers, clear the carry flip-flop, clear the bit counter, and go to RUN.
REQ-013 IDLE: on an edge with start=0, stay in IDLE with no change to sum or carry.
REQ-014 RUN: each edge processes one bit, LSB first, using a full adder built from two half-adder stages plus OR on the current LSBs and the carry flip-flop.
REQ-015 RUN: each edge shifts the sum bit into the MSB of a result shift register, right-shifts both operand registers, updates the carry flip-flop and increments the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; on the edge processing bit WIDTH-1, copy the completed result to sum and the final carry to carry, and go to DONE.
REQ-017 DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-018 Latency: start accepted at edge k gives done high during the cycle after edge k+WIDTH, with sum and carry valid from that same cycle.
REQ-019 busy SHALL be 1 exactly while state is RUN; done SHALL be 1 exactly while state is DONE.
REQ-020 start SHALL be ignored in RUN and DONE; operands in flight SHALL NOT change.
REQ-021 sum and carry SHALL hold their last result through IDLE and RUN until the next completion; partial results SHALL never appear on sum.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.
REQ-023 WIDTH=1: RUN lasts one edge; the result equals half-adder behaviour plus a zero carry-in.

Reset
REQ-024 On an edge with rst=1, SHALL set state=IDLE, busy=0, done=0, sum=0, carry=0, and clear the counter, carry flip-flop and shift registers.
REQ-025 rst SHALL take priority over start and over any in-progress RUN or DONE; an aborted operation SHALL produce no done pulse.
REQ-026 After rst is released, the first start SHALL be accepted normally.

Verification
REQ-027 WIDTH=8, a=8'hFF, b=8'h01, start pulse -> busy high for 8 cycles, then done=1 for 1 cycle, sum=8'h00, carry=1.
REQ-028 a=8'h5A, b=8'hA5 -> sum=8'hFF, carry=0 after 8 RUN cycles; a=0, b=0 -> sum=8'h00, carry=0.
REQ-029 start=1 held during RUN, with a and b changed mid-operation -> original operands' sum produced, one done pulse only.
REQ-030 rst=1 at RUN cycle 4 of a=8'hFF, b=8'hFF -> next cycle busy=0, done=0, sum=0, carry=0, and no done pulse follows.
REQ-031 Back-to-back: start reasserted in the cycle after done (IDLE) with a=8'h80, b=8'h80 -> accepted, sum=8'h00, carry=1; the previous result is held until then.
REQ-032 WIDTH=1, all four a/b combinations -> done 2 cycles after start; {carry,sum} equal to 00, 01, 01, 10.
